// File: rtl/ws_write_s.sv
// Write-S: reads one 8x8 block of signed S values, clips to 8 bits, packs 2 pixels/word, writes 32 SRAM words.
// Optional macro WS_CLIP_COUNT_EN adds a saturating count of clipped pixels on WS_clip_count.
module ws_write_s #(
  parameter logic [17:0] Y_BASE        = 18'd0,
  parameter logic [17:0] U_BASE        = 18'd38400,
  parameter logic [17:0] V_BASE        = 18'd57600,
  parameter int          Y_ROW_WORDS   = 160,
  parameter int          UV_ROW_WORDS  = 80,
  parameter int          Y_BLOCK_COLS  = 40,
  parameter int          UV_BLOCK_COLS = 20,
  parameter int          BLOCK_ROWS    = 30
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        WS_start,
  output logic        WS_done,
  output logic        WS_memory_end,
  output logic [6:0]  WS_read_address,
  input  logic [31:0] WS_read_data,
  output logic [17:0] WS_SRAM_address,
  output logic [15:0] WS_SRAM_write_data,
`ifdef WS_CLIP_COUNT_EN
  output logic [15:0] WS_clip_count,
`endif
  output logic        WS_SRAM_we_n
);

  typedef enum logic [1:0] {S_WS_IDLE, S_WS_READ, S_WS_LEAD_OUT, S_WS_DONE} state_t;
  typedef enum logic [1:0] {PL_Y, PL_U, PL_V} plane_t;

  state_t      state_q, state_d;
  plane_t      plane_q, plane_d;
  logic [5:0]  rd_addr_q, rd_addr_d;
  logic        lo_cnt_q, lo_cnt_d;
  logic        dat_vld_q, dat_vld_d;
  logic [5:0]  dat_idx_q, dat_idx_d;
  logic [7:0]  even_pix_q, even_pix_d;
  logic        even_clip_q, even_clip_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_wdata_q, sram_wdata_d;
  logic        we_n_q, we_n_d;
  logic        done_q, done_d;
  logic        mem_end_q, mem_end_d;
  logic [5:0]  cb_q, cb_d;
  logic [4:0]  rb_q, rb_d;
`ifdef WS_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic [16:0] clip_sum;
`endif

  logic        s_neg, s_big, s_clipped;
  logic [7:0]  s_pix;
  logic [17:0] base, row_words, wr_addr;
  logic [7:0]  pix_row;
  logic        cb_last, rb_last, last_block;

  // Full 32-bit signed compare: a large magnitude must never alias into range.
  always_comb begin
    s_neg     = WS_read_data[31];
    s_big     = !s_neg && (|WS_read_data[30:8]);
    s_clipped = s_neg || s_big;
    s_pix     = s_neg ? 8'h00 : (s_big ? 8'hFF : WS_read_data[7:0]);
  end

  always_comb begin
    base      = Y_BASE;
    row_words = 18'(Y_ROW_WORDS);
    cb_last   = (cb_q == 6'(Y_BLOCK_COLS - 1));
    if (plane_q == PL_U) begin
      base      = U_BASE;
      row_words = 18'(UV_ROW_WORDS);
      cb_last   = (cb_q == 6'(UV_BLOCK_COLS - 1));
    end else if (plane_q == PL_V) begin
      base      = V_BASE;
      row_words = 18'(UV_ROW_WORDS);
      cb_last   = (cb_q == 6'(UV_BLOCK_COLS - 1));
    end
    rb_last    = (rb_q == 5'(BLOCK_ROWS - 1));
    last_block = (plane_q == PL_V) && cb_last && rb_last;
    // Word k = dat_idx[5:1]; its block row r = idx[5:3], column c = idx[2:1].
    pix_row    = {rb_q, 3'b000} + {5'b0, dat_idx_q[5:3]};
    wr_addr    = base + 18'(pix_row) * row_words + 18'({cb_q, 2'b00}) + 18'(dat_idx_q[2:1]);
  end

  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    rd_addr_d    = rd_addr_q;
    lo_cnt_d     = lo_cnt_q;
    even_pix_d   = even_pix_q;
    even_clip_d  = even_clip_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = 1'b1;
    done_d       = 1'b0;
    mem_end_d    = mem_end_q;
    cb_d         = cb_q;
    rb_d         = rb_q;
    dat_vld_d    = (state_q == S_WS_READ);
    dat_idx_d    = rd_addr_q;
`ifdef WS_CLIP_COUNT_EN
    clip_cnt_d   = clip_cnt_q;
    clip_sum     = {1'b0, clip_cnt_q} + 17'(even_clip_q) + 17'(s_clipped);
`endif

    case (state_q)
      S_WS_IDLE: begin
        if (WS_start && !mem_end_q) begin
          state_d   = S_WS_READ;
          rd_addr_d = 6'd0;
        end
      end
      S_WS_READ: begin
        if (rd_addr_q == 6'd63) begin
          state_d  = S_WS_LEAD_OUT;
          lo_cnt_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 6'd1;
        end
      end
      S_WS_LEAD_OUT: begin
        if (lo_cnt_q) begin
          state_d   = S_WS_DONE;
          done_d    = 1'b1;
          mem_end_d = mem_end_q | last_block;
        end else begin
          lo_cnt_d = 1'b1;
        end
      end
      S_WS_DONE: begin
        state_d = S_WS_IDLE;
        if (!mem_end_q) begin
          if (cb_last) begin
            cb_d = 6'd0;
            if (rb_last) begin
              rb_d    = 5'd0;
              plane_d = (plane_q == PL_Y) ? PL_U : PL_V;
            end else begin
              rb_d = rb_q + 5'd1;
            end
          end else begin
            cb_d = cb_q + 6'd1;
          end
        end
      end
      default: state_d = S_WS_IDLE;
    endcase

    if (dat_vld_q) begin
      if (!dat_idx_q[0]) begin
        even_pix_d  = s_pix;
        even_clip_d = s_clipped;
      end else begin
        sram_addr_d  = wr_addr;
        sram_wdata_d = {even_pix_q, s_pix};
        we_n_d       = 1'b0;
`ifdef WS_CLIP_COUNT_EN
        clip_cnt_d   = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q      <= S_WS_IDLE;
      plane_q      <= PL_Y;
      rd_addr_q    <= 6'd0;
      lo_cnt_q     <= 1'b0;
      dat_vld_q    <= 1'b0;
      dat_idx_q    <= 6'd0;
      even_pix_q   <= 8'd0;
      even_clip_q  <= 1'b0;
      sram_addr_q  <= 18'd0;
      sram_wdata_q <= 16'd0;
      we_n_q       <= 1'b1;
      done_q       <= 1'b0;
      mem_end_q    <= 1'b0;
      cb_q         <= 6'd0;
      rb_q         <= 5'd0;
`ifdef WS_CLIP_COUNT_EN
      clip_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      plane_q      <= plane_d;
      rd_addr_q    <= rd_addr_d;
      lo_cnt_q     <= lo_cnt_d;
      dat_vld_q    <= dat_vld_d;
      dat_idx_q    <= dat_idx_d;
      even_pix_q   <= even_pix_d;
      even_clip_q  <= even_clip_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      done_q       <= done_d;
      mem_end_q    <= mem_end_d;
      cb_q         <= cb_d;
      rb_q         <= rb_d;
`ifdef WS_CLIP_COUNT_EN
      clip_cnt_q   <= clip_cnt_d;
`endif
    end
  end

  assign WS_done            = done_q;
  assign WS_memory_end      = mem_end_q;
  assign WS_read_address    = {1'b0, rd_addr_q};
  assign WS_SRAM_address    = sram_addr_q;
  assign WS_SRAM_write_data = sram_wdata_q;
  assign WS_SRAM_we_n       = we_n_q;
`ifdef WS_CLIP_COUNT_EN
  assign WS_clip_count      = clip_cnt_q;
`endif

endmodule

// File: tb/tb_ws_write_s.sv
// Bench for ws_write_s: full-size instance for timing/data/clip/addressing, reduced-geometry instance for plane walk.
module tb_ws_write_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        done_a, done_b, mend_a, mend_b, we_n_a, we_n_b;
  logic [6:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a = '0, rdata_b = '0;
  logic [17:0] saddr_a, saddr_b;
  logic [15:0] wdat_a, wdat_b;
`ifdef WS_CLIP_COUNT_EN
  logic [15:0] cc_a, cc_b;
`endif

  logic [31:0] s_mem [64];
  int tests = 0, fails = 0;

  always #10 clk = ~clk;

  ws_write_s dut_a (
    .CLOCK_50_I(clk), .Reset(rst), .WS_start(start_a), .WS_done(done_a),
    .WS_memory_end(mend_a), .WS_read_address(raddr_a), .WS_read_data(rdata_a),
    .WS_SRAM_address(saddr_a), .WS_SRAM_write_data(wdat_a),
`ifdef WS_CLIP_COUNT_EN
    .WS_clip_count(cc_a),
`endif
    .WS_SRAM_we_n(we_n_a)
  );

  ws_write_s #(.Y_BLOCK_COLS(2), .UV_BLOCK_COLS(1), .BLOCK_ROWS(2)) dut_b (
    .CLOCK_50_I(clk), .Reset(rst), .WS_start(start_b), .WS_done(done_b),
    .WS_memory_end(mend_b), .WS_read_address(raddr_b), .WS_read_data(rdata_b),
    .WS_SRAM_address(saddr_b), .WS_SRAM_write_data(wdat_b),
`ifdef WS_CLIP_COUNT_EN
    .WS_clip_count(cc_b),
`endif
    .WS_SRAM_we_n(we_n_b)
  );

  // S DPRAM model: registered read, one cycle of latency.
  always @(posedge clk) begin
    rdata_a <= s_mem[raddr_a[5:0]];
    rdata_b <= s_mem[raddr_b[5:0]];
  end

  int          n_wr, n_done, done_at;
  logic        mend_at_done;
  logic [17:0] w_addr [32];
  logic [15:0] w_dat  [32];
  int          w_cyc  [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one block on the selected instance and record writes/done for 80 cycles (cycle index i = t+i).
  task automatic run_block(input int sel, input bit pulses);
    n_wr = 0; n_done = 0; done_at = -1; mend_at_done = 1'b0;
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if ((sel == 0 ? we_n_a : we_n_b) == 1'b0) begin
        if (n_wr < 32) begin
          w_addr[n_wr] = (sel == 0) ? saddr_a : saddr_b;
          w_dat[n_wr]  = (sel == 0) ? wdat_a : wdat_b;
          w_cyc[n_wr]  = i;
        end
        n_wr++;
      end
      if ((sel == 0 ? done_a : done_b) == 1'b1) begin
        n_done++;
        done_at = i;
        mend_at_done = (sel == 0) ? mend_a : mend_b;
      end
      if (pulses) begin
        if (i == 20 || i == 67) begin
          if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        end else begin
          start_a = 1'b0; start_b = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [31:0] s_even;
    logic [31:0] s_odd;
    logic [15:0] exp_word;
  } clip_vec_t;

  typedef struct {
    logic [17:0] first;
    logic [17:0] row2;
    logic        mend;
  } plane_vec_t;

  clip_vec_t  cv [8];
  plane_vec_t pv [8];

  initial begin
    cv[0] = '{0, -32'sd5,          32'd300,        16'h00FF};
    cv[1] = '{1, 32'd0,            32'd255,        16'h00FF};
    cv[2] = '{2, 32'd256,          32'hFFFF_FFFF,  16'hFF00};
    cv[3] = '{3, 32'h8000_0000,    32'h7FFF_FFFF,  16'h00FF};
    cv[4] = '{4, 32'd128,          32'd127,        16'h807F};
    cv[5] = '{5, 32'd256,          32'd255,        16'hFFFF};
    cv[6] = '{6, 32'hFFFF_FF00,    32'd511,        16'h00FF};
    cv[7] = '{7, 32'd1,            32'h0001_0005,  16'h01FF};

    pv[0] = '{18'd0,     18'd160,   1'b0};
    pv[1] = '{18'd4,     18'd164,   1'b0};
    pv[2] = '{18'd1280,  18'd1440,  1'b0};
    pv[3] = '{18'd1284,  18'd1444,  1'b0};
    pv[4] = '{18'd38400, 18'd38480, 1'b0};
    pv[5] = '{18'd39040, 18'd39120, 1'b0};
    pv[6] = '{18'd57600, 18'd57680, 1'b0};
    pv[7] = '{18'd58240, 18'd58320, 1'b1};

    for (int a = 0; a < 64; a++) s_mem[a] = 32'(a);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   32'(done_a),  32'd0);
    check("rst_mend",   32'(mend_a),  32'd0);
    check("rst_raddr",  32'(raddr_a), 32'd0);
    check("rst_saddr",  32'(saddr_a), 32'd0);
    check("rst_wdata",  32'(wdat_a),  32'd0);
    check("rst_we_n",   32'(we_n_a),  32'd1);
    @(negedge clk); rst = 1'b0;

    // Block 1: S[a]=a, full timing and address check.
    run_block(0, 1'b0);
    check("b1_nwr",   32'(n_wr),   32'd32);
    check("b1_ndone", 32'(n_done), 32'd1);
    check("b1_done_at", 32'(done_at), 32'd67);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("b1_addr%0d", k), 32'(w_addr[k]), 32'((k >> 2) * 160 + (k & 3)));
      check($sformatf("b1_dat%0d", k),  32'(w_dat[k]),  32'({8'(2 * k), 8'(2 * k + 1)}));
      check($sformatf("b1_cyc%0d", k),  32'(w_cyc[k]),  32'(4 + 2 * k));
    end
    check("b1_raddr_hold", 32'(raddr_a), 32'd63);

    // Block 2: stray start pulses mid-block and in the done cycle change nothing.
    run_block(0, 1'b1);
    check("b2_nwr",     32'(n_wr),    32'd32);
    check("b2_ndone",   32'(n_done),  32'd1);
    check("b2_done_at", 32'(done_at), 32'd67);
    check("b2_first",   32'(w_addr[0]), 32'd4);
    check("b2_last_cyc", 32'(w_cyc[31]), 32'd66);

    // Blocks 3 and 4: clipping vectors.
    for (int a = 0; a < 64; a++) s_mem[a] = 32'd0;
    foreach (cv[i]) begin
      s_mem[2 * cv[i].k]     = cv[i].s_even;
      s_mem[2 * cv[i].k + 1] = cv[i].s_odd;
    end
    run_block(0, 1'b0);
    check("b3_first", 32'(w_addr[0]), 32'd8);
    foreach (cv[i]) check($sformatf("clip%0d", i), 32'(w_dat[cv[i].k]), 32'(cv[i].exp_word));
    check("b3_zero_word", 32'(w_dat[20]), 32'd0);
`ifdef WS_CLIP_COUNT_EN
    check("b3_clipcnt", 32'(cc_a), 32'd10);
`endif
    run_block(0, 1'b0);
    check("b4_first", 32'(w_addr[0]), 32'd12);
`ifdef WS_CLIP_COUNT_EN
    check("b4_clipcnt", 32'(cc_a), 32'd20);
`endif

    // Blocks 5..41: row wrap into block row 1.
    for (int b = 5; b <= 40; b++) run_block(0, 1'b0);
    check("b40_first", 32'(w_addr[0]), 32'd156);
    run_block(0, 1'b0);
    check("b41_first", 32'(w_addr[0]), 32'd1280);
    check("b41_row2",  32'(w_addr[4]), 32'd1440);

    // Reset in the cycle of write 10 aborts the block.
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int i = 1; i < 24; i++) begin @(posedge clk); #1; end
    check("abort_we_at_w10", 32'(we_n_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_we_n",  32'(we_n_a),  32'd1);
    check("abort_raddr", 32'(raddr_a), 32'd0);
    check("abort_saddr", 32'(saddr_a), 32'd0);
    check("abort_done",  32'(done_a),  32'd0);
`ifdef WS_CLIP_COUNT_EN
    check("abort_clipcnt", 32'(cc_a), 32'd0);
`endif
    run_block(0, 1'b0);
    check("post_rst_first", 32'(w_addr[0]), 32'd0);
    check("post_rst_cyc",   32'(w_cyc[0]),  32'd4);
    check("post_rst_mend",  32'(mend_a),    32'd0);

    // Reduced-geometry instance: walk Y, U, V planes to memory end.
    foreach (pv[i]) begin
      run_block(1, 1'b0);
      check($sformatf("pl%0d_first", i), 32'(w_addr[0]), 32'(pv[i].first));
      check($sformatf("pl%0d_row2", i),  32'(w_addr[4]), 32'(pv[i].row2));
      check($sformatf("pl%0d_mend", i),  32'(mend_at_done), 32'(pv[i].mend));
      check($sformatf("pl%0d_ndone", i), 32'(n_done), 32'd1);
    end
    run_block(1, 1'b0);
    check("end_nwr",   32'(n_wr),   32'd0);
    check("end_ndone", 32'(n_done), 32'd0);
    check("end_mend",  32'(mend_b), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("end_rst_mend", 32'(mend_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
